// File: rtl/bin2bcd_display_feed_if.sv
// Handshake and data bundle between the ALU side and the BCD converter.
// master drives value/start; slave returns status and the packed BCD word.
interface bin2bcd_display_feed_if;
  logic [15:0] in;
  logic        start;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  modport master (
    output in,
    output start,
    input  busy,
    input  done,
    input  ovf,
    input  bcd_out
  );

  modport slave (
    input  in,
    input  start,
    output busy,
    output done,
    output ovf,
    output bcd_out
  );
endinterface

// File: rtl/bin2bcd_display_feed.sv
// Sequential double-dabble converter feeding the 4-digit display mux.
// Optional BIN2BCD_AUTO_REFRESH_EN: reconvert whenever the input changes.
module bin2bcd_display_feed #(
  parameter int          OVF_MODE    = 0,
  parameter logic [15:0] OVF_PATTERN = 16'hEEEE
) (
  input logic                   Sclk,
  input logic                   reset,
  bin2bcd_display_feed_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t      state;
  logic [15:0] bin_q;
  logic [19:0] scratch;
  logic [19:0] adj;
  logic [4:0]  cnt;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic [15:0] bcd_q;
  logic        kick;

`ifdef BIN2BCD_AUTO_REFRESH_EN
  logic [15:0] last_in;

  // Last sampled input, so a changed ALU result retriggers conversion.
  always_ff @(posedge Sclk) begin
    if (reset) begin
      last_in <= 16'h0000;
    end else if (state == IDLE && kick) begin
      last_in <= bus.in;
    end
  end

  assign kick = bus.start | (bus.in != last_in);
`else
  assign kick = bus.start;
`endif

  // Add 3 to every BCD digit >= 5 ahead of the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge Sclk) begin
    if (reset) begin
      state   <= IDLE;
      bin_q   <= 16'h0000;
      scratch <= 20'h00000;
      cnt     <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (kick) begin
            bin_q   <= bus.in;
            scratch <= 20'h00000;
            cnt     <= 5'd0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[18:0], bin_q[15]};
          bin_q   <= {bin_q[14:0], 1'b0};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (scratch[19:16] != 4'h0) begin
            ovf_q <= 1'b1;
            bcd_q <= (OVF_MODE != 0) ? 16'h9999 : OVF_PATTERN;
          end else begin
            ovf_q <= 1'b0;
            bcd_q <= scratch[15:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// Bench for bin2bcd_display_feed: both overflow modes side by side,
// table vectors plus hand-written multi-cycle sequences.
module tb_bin2bcd_display_feed;

  logic Sclk = 1'b0;
  logic reset;

  always #5 Sclk = ~Sclk;

  bin2bcd_display_feed_if b0 ();
  bin2bcd_display_feed_if b1 ();

  bin2bcd_display_feed #(.OVF_MODE(0)) dut0 (
    .Sclk  (Sclk),
    .reset (reset),
    .bus   (b0.slave)
  );

  bin2bcd_display_feed #(.OVF_MODE(1)) dut1 (
    .Sclk  (Sclk),
    .reset (reset),
    .bus   (b1.slave)
  );

  int errors = 0;
  int checks = 0;
  int ndone0 = 0;
  int ndone1 = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] e0;
  logic [16:0] e1;

  typedef struct {
    logic [15:0] v;
    logic [15:0] x0;
    logic [15:0] x1;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [15:0] v, input logic s);
    b0.in = v;
    b1.in = v;
    b0.start = s;
    b1.start = s;
  endtask

  task automatic push(input logic [15:0] x0, input logic [15:0] x1,
                      input logic o);
    q0.push_back({o, x0});
    q1.push_back({o, x1});
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    forever begin
      @(posedge Sclk);
      #1;
      lat++;
      if (b0.done === 1'b1) break;
      if (lat >= 40) begin
        checks++;
        errors++;
        $display("FAIL %s: no done after %0d cycles", name, lat);
        break;
      end
    end
  endtask

  // Scoreboard for the pattern-mode instance.
  always @(negedge Sclk) begin
    if (b0.done === 1'b1) begin
      ndone0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 done: unexpected pulse, bcd=%h", b0.bcd_out);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 bcd", {16'h0, b0.bcd_out}, {16'h0, e0[15:0]});
        chk("dut0 ovf", {31'h0, b0.ovf}, {31'h0, e0[16]});
      end
    end
  end

  // Scoreboard for the saturating instance.
  always @(negedge Sclk) begin
    if (b1.done === 1'b1) begin
      ndone1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 done: unexpected pulse, bcd=%h", b1.bcd_out);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 bcd", {16'h0, b1.bcd_out}, {16'h0, e1[15:0]});
        chk("dut1 ovf", {31'h0, b1.ovf}, {31'h0, e1[16]});
      end
    end
  end

  initial begin
    int lat;
    int nd;
    tbl = '{
      '{16'd1234,  16'h1234, 16'h1234, 1'b0},
      '{16'd0,     16'h0000, 16'h0000, 1'b0},
      '{16'd9999,  16'h9999, 16'h9999, 1'b0},
      '{16'd10000, 16'hEEEE, 16'h9999, 1'b1},
      '{16'd65535, 16'hEEEE, 16'h9999, 1'b1},
      '{16'd1,     16'h0001, 16'h0001, 1'b0},
      '{16'd10,    16'h0010, 16'h0010, 1'b0},
      '{16'd99,    16'h0099, 16'h0099, 1'b0},
      '{16'd5000,  16'h5000, 16'h5000, 1'b0},
      '{16'd4095,  16'h4095, 16'h4095, 1'b0},
      '{16'd12345, 16'hEEEE, 16'h9999, 1'b1},
      '{16'd9990,  16'h9990, 16'h9990, 1'b0}
    };

    reset = 1'b1;
    drv(16'd0, 1'b0);
    repeat (3) @(posedge Sclk);
    #1;
    chk("reset busy", {31'h0, b0.busy}, 32'h0);
    chk("reset done", {31'h0, b0.done}, 32'h0);
    chk("reset ovf", {31'h0, b0.ovf}, 32'h0);
    chk("reset bcd", {16'h0, b0.bcd_out}, 32'h0);
    chk("reset bcd1", {16'h0, b1.bcd_out}, 32'h0);
    reset = 1'b0;
    @(posedge Sclk);
    #1;
    chk("idle busy", {31'h0, b0.busy}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].v, 1'b1);
      push(tbl[i].x0, tbl[i].x1, tbl[i].ovf);
      @(posedge Sclk);
      #1;
      drv(tbl[i].v, 1'b0);
      chk("busy after start", {31'h0, b0.busy}, 32'h1);
      wait_done("table", lat);
      chk("latency", lat, 32'd17);
      chk("busy at done", {31'h0, b0.busy}, 32'h0);
      @(posedge Sclk);
      #1;
      chk("done one cycle", {31'h0, b0.done}, 32'h0);
    end

    // Input change and start during a conversion are ignored.
    nd = ndone0;
    drv(16'd42, 1'b1);
    push(16'h0042, 16'h0042, 1'b0);
    @(posedge Sclk);
    #1;
    drv(16'd42, 1'b0);
    repeat (4) @(posedge Sclk);
    #1;
    drv(16'd7, 1'b1);
    @(posedge Sclk);
    #1;
    drv(16'd7, 1'b0);
    wait_done("mid change", lat);
`ifdef BIN2BCD_AUTO_REFRESH_EN
    push(16'h0007, 16'h0007, 1'b0);
    wait_done("auto follow", lat);
    repeat (25) @(posedge Sclk);
    #1;
    chk("held bcd", {16'h0, b0.bcd_out}, 32'h0007);
    chk("mid change dones", ndone0 - nd, 32'd2);
`else
    repeat (25) @(posedge Sclk);
    #1;
    chk("held bcd", {16'h0, b0.bcd_out}, 32'h0042);
    chk("mid change dones", ndone0 - nd, 32'd1);
`endif

    // Reset in the middle of a conversion.
    drv(16'd5678, 1'b1);
    @(posedge Sclk);
    #1;
    drv(16'd5678, 1'b0);
    repeat (7) @(posedge Sclk);
    #1;
    reset = 1'b1;
    drv(16'd0, 1'b0);
    @(posedge Sclk);
    #1;
    chk("abort busy", {31'h0, b0.busy}, 32'h0);
    chk("abort bcd", {16'h0, b0.bcd_out}, 32'h0);
    chk("abort ovf", {31'h0, b0.ovf}, 32'h0);
    chk("abort done", {31'h0, b0.done}, 32'h0);
    reset = 1'b0;
    nd = ndone0;
    repeat (25) @(posedge Sclk);
    #1;
    chk("no done after abort", ndone0 - nd, 32'd0);
    drv(16'd5678, 1'b1);
    push(16'h5678, 16'h5678, 1'b0);
    @(posedge Sclk);
    #1;
    drv(16'd5678, 1'b0);
    wait_done("after abort", lat);
    chk("after abort latency", lat, 32'd17);

    // Start held high: back-to-back conversions.
    @(posedge Sclk);
    #1;
    drv(16'd321, 1'b1);
    push(16'h0321, 16'h0321, 1'b0);
    push(16'h8000, 16'h8000, 1'b0);
    @(posedge Sclk);
    #1;
    drv(16'd8000, 1'b1);
    wait_done("b2b first", lat);
    chk("b2b first latency", lat, 32'd17);
    @(posedge Sclk);
    #1;
    drv(16'd8000, 1'b0);
    chk("b2b restart busy", {31'h0, b0.busy}, 32'h1);
    wait_done("b2b second", lat);
    chk("b2b second latency", lat, 32'd17);

`ifdef BIN2BCD_AUTO_REFRESH_EN
    // Input-driven refresh with start tied low.
    reset = 1'b1;
    drv(16'd0, 1'b0);
    @(posedge Sclk);
    #1;
    reset = 1'b0;
    nd = ndone0;
    repeat (25) @(posedge Sclk);
    #1;
    chk("auto idle zero", ndone0 - nd, 32'd0);
    drv(16'd321, 1'b0);
    push(16'h0321, 16'h0321, 1'b0);
    wait_done("auto 321", lat);
    repeat (25) @(posedge Sclk);
    #1;
    drv(16'd8000, 1'b0);
    push(16'h8000, 16'h8000, 1'b0);
    wait_done("auto 8000", lat);
    repeat (25) @(posedge Sclk);
    #1;
    chk("auto dones", ndone0 - nd, 32'd2);
    chk("auto bcd", {16'h0, b0.bcd_out}, 32'h8000);
`endif

    repeat (3) @(posedge Sclk);
    #1;
    chk("dut0 queue drained", q0.size(), 32'd0);
    chk("dut1 queue drained", q1.size(), 32'd0);
    chk("done count match", ndone0, ndone1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
